// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM operand bypass, load-use stall
// detection and branch-flush bubble insertion.
module id_ex_stage #(
    parameter int W    = 32,
    parameter int PCW  = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            rf_ena,
    input  logic            id_valid,
    input  logic [4:0]      id_rsc,
    input  logic [4:0]      id_rtc,
    input  logic [W-1:0]    id_rs,
    input  logic [W-1:0]    id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [4:0]      id_rdc,
    input  logic            id_rf_w,
    input  logic            id_is_load,
    input  logic [3:0]      id_alu_op,
    input  logic [W-1:0]    id_imm,
    input  logic [PCW-1:0]  id_pc,
    input  logic [W-1:0]    ex_alu_result,
    input  logic [4:0]      mem_rdc,
    input  logic            mem_rf_w,
    input  logic [W-1:0]    mem_result,
    input  logic            flush,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_rf_w,
    output logic            ex_is_load,
    output logic [4:0]      ex_rdc,
    output logic [3:0]      ex_alu_op,
    output logic [W-1:0]    ex_rs_val,
    output logic [W-1:0]    ex_rt_val,
    output logic [W-1:0]    ex_imm,
    output logic [PCW-1:0]  ex_pc,
    output logic [CNTW-1:0] stall_cnt
);

    logic            ex_valid_reg;
    logic            ex_rf_w_reg;
    logic            ex_is_load_reg;
    logic [4:0]      ex_rdc_reg;
    logic [3:0]      ex_alu_op_reg;
    logic [W-1:0]    ex_rs_val_reg;
    logic [W-1:0]    ex_rt_val_reg;
    logic [W-1:0]    ex_imm_reg;
    logic [PCW-1:0]  ex_pc_reg;
    logic [CNTW-1:0] stall_cnt_reg;

    // Source 0 is rs, source 1 is rt.
    logic [4:0]   src_c    [2];
    logic [W-1:0] src_rf   [2];
    logic [W-1:0] src_next [2];
    logic [1:0]   src_uses;
    logic [1:0]   src_hit;
    logic         load_use;
    logic         bubble;

    assign src_c[0]  = id_rsc;
    assign src_c[1]  = id_rtc;
    assign src_rf[0] = id_rs;
    assign src_rf[1] = id_rt;
    assign src_uses  = {id_uses_rt, id_uses_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = ex_valid_reg & ex_rf_w_reg & (ex_rdc_reg != 5'd0)
                               & (ex_rdc_reg == src_c[gi]);

            // First match wins; a load in EX cannot forward, it stalls instead.
            always_comb begin
                src_next[gi] = src_rf[gi];
                if (src_c[gi] == 5'd0)
                    src_next[gi] = '0;
                else if (src_hit[gi] && !ex_is_load_reg)
                    src_next[gi] = ex_alu_result;
                else if (mem_rf_w && (mem_rdc == src_c[gi]))
                    src_next[gi] = mem_result;
            end
        end
    endgenerate

    assign load_use = id_valid & ex_is_load_reg & |(src_uses & src_hit);
    assign stall    = load_use & ~flush & ~rst;
    assign rf_ena   = ~rst;
    assign bubble   = rst | flush | load_use | ~id_valid;

    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_valid_reg   <= 1'b0;
            ex_rf_w_reg    <= 1'b0;
            ex_is_load_reg <= 1'b0;
            ex_rdc_reg     <= 5'd0;
            ex_alu_op_reg  <= 4'd0;
            ex_rs_val_reg  <= '0;
            ex_rt_val_reg  <= '0;
            ex_imm_reg     <= '0;
            ex_pc_reg      <= '0;
        end else begin
            ex_valid_reg   <= 1'b1;
            ex_rf_w_reg    <= id_rf_w;
            ex_is_load_reg <= id_is_load;
            ex_rdc_reg     <= id_rdc;
            ex_alu_op_reg  <= id_alu_op;
            ex_rs_val_reg  <= src_next[0];
            ex_rt_val_reg  <= src_next[1];
            ex_imm_reg     <= id_imm;
            ex_pc_reg      <= id_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if (stall && (stall_cnt_reg != {CNTW{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_rf_w    = ex_rf_w_reg;
    assign ex_is_load = ex_is_load_reg;
    assign ex_rdc     = ex_rdc_reg;
    assign ex_alu_op  = ex_alu_op_reg;
    assign ex_rs_val  = ex_rs_val_reg;
    assign ex_rt_val  = ex_rt_val_reg;
    assign ex_imm     = ex_imm_reg;
    assign ex_pc      = ex_pc_reg;
    assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass priority, load-use stall, flush,
// $0 handling, reset and counter saturation (second instance with CNTW=4).
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs, id_uses_rt, id_rf_w, id_is_load;
    logic [4:0]  id_rsc, id_rtc, id_rdc, mem_rdc;
    logic [31:0] id_rs, id_rt, id_imm, id_pc, ex_alu_result, mem_result;
    logic [3:0]  id_alu_op;
    logic        mem_rf_w, flush;

    logic        rf_ena, stall, ex_valid, ex_rf_w, ex_is_load;
    logic [4:0]  ex_rdc;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc;
    logic [15:0] stall_cnt;

    logic        s_rf_ena, s_stall, s_ex_valid, s_ex_rf_w, s_ex_is_load;
    logic [4:0]  s_ex_rdc;
    logic [3:0]  s_ex_alu_op;
    logic [31:0] s_ex_rs_val, s_ex_rt_val, s_ex_imm, s_ex_pc;
    logic [3:0]  s_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .rf_ena(rf_ena),
        .id_valid(id_valid), .id_rsc(id_rsc), .id_rtc(id_rtc),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rdc(id_rdc), .id_rf_w(id_rf_w), .id_is_load(id_is_load),
        .id_alu_op(id_alu_op), .id_imm(id_imm), .id_pc(id_pc),
        .ex_alu_result(ex_alu_result), .mem_rdc(mem_rdc), .mem_rf_w(mem_rf_w),
        .mem_result(mem_result), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_rf_w(ex_rf_w), .ex_is_load(ex_is_load),
        .ex_rdc(ex_rdc), .ex_alu_op(ex_alu_op), .ex_rs_val(ex_rs_val),
        .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_pc(ex_pc), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.CNTW(4)) dut_sat (
        .clk(clk), .rst(rst), .rf_ena(s_rf_ena),
        .id_valid(id_valid), .id_rsc(id_rsc), .id_rtc(id_rtc),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rdc(id_rdc), .id_rf_w(id_rf_w), .id_is_load(id_is_load),
        .id_alu_op(id_alu_op), .id_imm(id_imm), .id_pc(id_pc),
        .ex_alu_result(ex_alu_result), .mem_rdc(mem_rdc), .mem_rf_w(mem_rf_w),
        .mem_result(mem_result), .flush(flush), .stall(s_stall),
        .ex_valid(s_ex_valid), .ex_rf_w(s_ex_rf_w), .ex_is_load(s_ex_is_load),
        .ex_rdc(s_ex_rdc), .ex_alu_op(s_ex_alu_op), .ex_rs_val(s_ex_rs_val),
        .ex_rt_val(s_ex_rt_val), .ex_imm(s_ex_imm), .ex_pc(s_ex_pc), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rsc = 0; id_rtc = 0; id_rs = 0; id_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_rdc = 0; id_rf_w = 0; id_is_load = 0;
        id_alu_op = 0; id_imm = 0; id_pc = 0; ex_alu_result = 0;
        mem_rdc = 0; mem_rf_w = 0; mem_result = 0; flush = 0;
    endtask

    task automatic drive_lw4();
        idle();
        id_valid = 1; id_is_load = 1; id_rf_w = 1; id_rdc = 5'd4; id_alu_op = 4'd1;
        id_imm = 32'h20; id_pc = 32'h200;
    endtask

    task automatic drive_add_uses4();
        idle();
        id_valid = 1; id_rsc = 5'd4; id_uses_rs = 1; id_rs = 32'h1111; id_rdc = 5'd8;
        id_rf_w = 1; id_alu_op = 4'd2; id_pc = 32'h204;
    endtask

    initial begin
        // Reset with random garbage on the inputs
        rst = 1;
        id_valid = 1; id_rsc = 5'($urandom); id_rtc = 5'($urandom);
        id_rs = $urandom; id_rt = $urandom; id_uses_rs = 1; id_uses_rt = 1;
        id_rdc = 5'($urandom); id_rf_w = 1; id_is_load = 1; id_alu_op = 4'($urandom);
        id_imm = $urandom; id_pc = $urandom; ex_alu_result = $urandom;
        mem_rdc = 5'($urandom); mem_rf_w = 1; mem_result = $urandom; flush = 0;
        tick();
        tick();
        check("rst_stall", stall, 0);
        check("rst_rf_ena", rf_ena, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_ctrl", {ex_rf_w, ex_is_load, ex_rdc, ex_alu_op}, 0);
        check("rst_ex_data", {ex_rs_val, ex_rt_val}, 0);
        check("rst_ex_imm_pc", {ex_imm, ex_pc}, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst = 0;
        idle();
        #1;
        check("rf_ena_run", rf_ena, 1);

        // ADD $3 enters EX
        id_valid = 1; id_rsc = 5'd1; id_rtc = 5'd2; id_rs = 32'h7; id_rt = 32'h9;
        id_uses_rs = 1; id_uses_rt = 1; id_rdc = 5'd3; id_rf_w = 1; id_alu_op = 4'd2;
        id_imm = 32'h10; id_pc = 32'h100;
        tick();
        check("add_valid", ex_valid, 1);
        check("add_rdc", ex_rdc, 3);
        check("add_rs_rt", {ex_rs_val, ex_rt_val}, {32'h7, 32'h9});
        check("add_imm_pc", {ex_imm, ex_pc}, {32'h10, 32'h100});
        check("add_op", {ex_rf_w, ex_is_load, ex_alu_op}, {1'b1, 1'b0, 4'd2});

        // SUB reads $3 while ADD is in EX
        idle();
        ex_alu_result = 32'h10; id_valid = 1; id_rsc = 5'd3; id_uses_rs = 1;
        id_rs = 32'hDEAD_BEEF; id_rdc = 5'd6; id_rf_w = 1; id_alu_op = 4'd3; id_pc = 32'h104;
        #1;
        check("exbyp_stall", stall, 0);
        tick();
        check("exbyp_rs", ex_rs_val, 32'h10);
        check("exbyp_rdc", ex_rdc, 6);

        // Producer of $5 enters EX
        idle();
        id_valid = 1; id_rdc = 5'd5; id_rf_w = 1; id_pc = 32'h108;
        tick();
        // EX and MEM both write $5: EX is younger and wins
        idle();
        ex_alu_result = 32'h66; mem_rdc = 5'd5; mem_rf_w = 1; mem_result = 32'h55;
        id_valid = 1; id_rtc = 5'd5; id_uses_rt = 1; id_rt = 32'h77; id_rdc = 5'd7;
        id_rf_w = 1; id_pc = 32'h10C;
        tick();
        check("prio_ex_rt", ex_rt_val, 32'h66);
        // EX now holds $7, only MEM matches
        tick();
        check("prio_mem_rt", ex_rt_val, 32'h55);
        mem_rf_w = 0;
        tick();
        check("nobyp_rt", ex_rt_val, 32'h77);

        // Load-use: one stall, one bubble, then MEM forward
        drive_lw4();
        tick();
        check("lw_is_load", ex_is_load, 1);
        drive_add_uses4();
        #1;
        check("lu_stall", stall, 1);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_bubble_ctrl", {ex_rf_w, ex_is_load, ex_rdc, ex_alu_op}, 0);
        check("lu_cnt", stall_cnt, 1);
        mem_rdc = 5'd4; mem_rf_w = 1; mem_result = 32'hCAFE_0001;
        #1;
        check("lu_stall_drop", stall, 0);
        tick();
        check("lu_mem_rs", ex_rs_val, 32'hCAFE_0001);
        check("lu_valid", ex_valid, 1);
        check("lu_cnt_hold", stall_cnt, 1);

        // Flush together with load-use
        drive_lw4();
        tick();
        drive_add_uses4();
        flush = 1;
        #1;
        check("fl_stall", stall, 0);
        tick();
        check("fl_bubble", ex_valid, 0);
        check("fl_cnt", stall_cnt, 1);

        // $0 never forwards
        idle();
        id_valid = 1; id_rdc = 5'd0; id_rf_w = 1; id_pc = 32'h300;
        tick();
        idle();
        ex_alu_result = 32'hFFFF_FFFF; mem_rdc = 5'd0; mem_rf_w = 1; mem_result = 32'h12;
        id_valid = 1; id_rsc = 5'd0; id_uses_rs = 1; id_rs = 32'hABCD; id_rdc = 5'd9;
        id_rf_w = 1; id_pc = 32'h304;
        tick();
        check("zero_rs", ex_rs_val, 0);

        // 20 more stall cycles; CNTW=4 instance saturates
        for (int i = 0; i < 20; i++) begin
            drive_lw4();
            tick();
            drive_add_uses4();
            tick();
        end
        check("sat_cnt16", stall_cnt, 21);
        check("sat_cnt4", s_stall_cnt, 4'hF);

        // Reset during a load-use hazard
        drive_lw4();
        tick();
        drive_add_uses4();
        rst = 1;
        #1;
        check("rst_mid_stall", stall, 0);
        tick();
        check("rst_mid_valid", ex_valid, 0);
        check("rst_mid_cnt", stall_cnt, 0);
        check("rst_mid_cnt4", s_stall_cnt, 0);
        rst = 0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
